// File: rtl/tc77_pkg.sv
// Shared types and frame constants for the TC77 temperature sensor reader.
package tc77_pkg;

  // Reader FSM states (ST_ prefix avoids the 'wait' keyword).
  typedef enum logic [2:0] {
    ST_WAIT,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_HOLD,
    ST_EVAL
  } tc77_state_e;

  // One read frame: 13-bit temperature, CONV flag, two filler bits.
  localparam int unsigned TC77_FRAME_BITS = 16;
  localparam int unsigned TC77_CONV_BIT   = 2;
  localparam int unsigned TC77_TEMP_MSB   = 15;
  localparam int unsigned TC77_TEMP_LSB   = 3;
  localparam int unsigned TC77_TEMP_W     = TC77_TEMP_MSB - TC77_TEMP_LSB + 1;

  // Larger of two sizing parameters.
  function automatic int unsigned tc77_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tc77_sck_gen.sv
// Half-period counter for the TC77 serial clock.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_en            count while the FSM is in LOW or HIGH
//   i_low           1 while SCK is low (LOW state)
//   o_sck_fall_c    last cycle of a high half: SCK may fall next
//   o_sample_en_c   last cycle of a low half: shift sio_q in
//   o_sck_rise_c    last cycle of a low half: SCK rises next
module tc77_sck_gen
  import tc77_pkg::*;
#(
  parameter int unsigned SCK_HALF = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_low,
  output logic o_sck_fall_c,
  output logic o_sample_en_c,
  output logic o_sck_rise_c
);

  localparam int unsigned HALF_W = $clog2(SCK_HALF);

  logic [HALF_W-1:0] r_cnt;
  logic              w_half_end;

  assign w_half_end = i_en && (r_cnt == HALF_W'(SCK_HALF - 1));

  // Counter restarts on every half boundary and whenever disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || w_half_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + HALF_W'(1);
    end
  end

  // Sampling happens SCK_HALF-1 cycles after the fall, i.e. just before the rise.
  assign o_sample_en_c = w_half_end && i_low;
  assign o_sck_rise_c  = w_half_end && i_low;
  assign o_sck_fall_c  = w_half_end && !i_low;

endmodule

// File: rtl/tc77_reader.sv
// Periodic / on-request reader for a TC77 SPI temperature sensor with a
// hysteretic over-temperature flag. Read-only: SIO is an input only.
// Ports:
//   MCLK, nRESET   clock, async active-low reset
//   TEMP_REQ       1-cycle request to start a frame while waiting
//   nCS, SCK       sensor chip select (active low) and serial clock (idles high)
//   SIO            sensor serial data
//   BUSY           1 from nCS fall through the evaluation cycle
//   TEMP_DATA      last valid 13-bit reading, 0.0625 C per LSB
//   TEMP_DEG       TEMP_DATA[12:4], signed whole degrees
//   TEMP_VALID     sticky: some frame has reported CONV=1
//   TEMP_STB       1-cycle pulse when TEMP_DATA updates
//   OVERTEMP       set at >= OT_SET_DEG, cleared below OT_CLR_DEG
module tc77_reader
  import tc77_pkg::*;
#(
  parameter int unsigned SCK_HALF    = 8,
  parameter int unsigned CS_SETUP    = 4,
  parameter int unsigned CS_HOLD     = 4,
  parameter int unsigned POLL_PERIOD = 4800000,
  parameter int unsigned RETRY_DELAY = 48000,
  parameter int          OT_SET_DEG  = 45,
  parameter int          OT_CLR_DEG  = 40
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic        TEMP_REQ,
  output logic        nCS,
  output logic        SCK,
  input  logic        SIO,
  output logic        BUSY,
  output logic [12:0] TEMP_DATA,
  output logic [8:0]  TEMP_DEG,
  output logic        TEMP_VALID,
  output logic        TEMP_STB,
  output logic        OVERTEMP
);

  localparam int unsigned TMR_W = $clog2(tc77_max(POLL_PERIOD, RETRY_DELAY));
  localparam int unsigned CNT_W = $clog2(tc77_max(CS_SETUP, CS_HOLD)) + 1;
  localparam int unsigned BIT_W = $clog2(TC77_FRAME_BITS) + 1;
  localparam int unsigned DEG_W = TC77_TEMP_W - 4;

  localparam logic signed [DEG_W-1:0] OT_SET_S = DEG_W'(OT_SET_DEG);
  localparam logic signed [DEG_W-1:0] OT_CLR_S = DEG_W'(OT_CLR_DEG);

  tc77_state_e                r_state, w_state_nxt;
  logic [TMR_W-1:0]           r_timer, w_timer_nxt;
  logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]           r_bitcnt, w_bitcnt_nxt, w_bitcnt_inc;
  logic [TC77_FRAME_BITS-1:0] r_shreg, w_shreg_nxt;
  logic                       r_sio_q;
  logic                       r_ncs, w_ncs_nxt;
  logic                       r_sck, w_sck_nxt;
  logic                       r_busy, w_busy_nxt;
  logic [TC77_TEMP_W-1:0]     r_temp, w_temp_nxt;
  logic                       r_valid, w_valid_nxt;
  logic                       r_stb, w_stb_nxt;
  logic                       r_ot, w_ot_nxt;

  logic                       w_sck_en, w_sck_low;
  logic                       w_sck_fall, w_sample_en, w_sck_rise;
  logic [TC77_TEMP_W-1:0]     w_new_temp;
  logic signed [DEG_W-1:0]    w_new_deg;
  logic                       w_conv;

  assign w_sck_en     = (r_state == ST_LOW) || (r_state == ST_HIGH);
  assign w_sck_low    = (r_state == ST_LOW);
  assign w_new_temp   = r_shreg[TC77_TEMP_MSB:TC77_TEMP_LSB];
  assign w_new_deg    = w_new_temp[TC77_TEMP_W-1:4];
  assign w_conv       = r_shreg[TC77_CONV_BIT];
  assign w_bitcnt_inc = r_bitcnt + BIT_W'(1);

  tc77_sck_gen #(
    .SCK_HALF (SCK_HALF)
  ) u_sck_gen (
    .clk           (MCLK),
    .rst_n         (nRESET),
    .i_en          (w_sck_en),
    .i_low         (w_sck_low),
    .o_sck_fall_c  (w_sck_fall),
    .o_sample_en_c (w_sample_en),
    .o_sck_rise_c  (w_sck_rise)
  );

  // State and output registers.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state  <= ST_WAIT;
      r_timer  <= '0;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_sio_q  <= 1'b0;
      r_ncs    <= 1'b1;
      r_sck    <= 1'b1;
      r_busy   <= 1'b0;
      r_temp   <= '0;
      r_valid  <= 1'b0;
      r_stb    <= 1'b0;
      r_ot     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shreg  <= w_shreg_nxt;
      r_sio_q  <= SIO;
      r_ncs    <= w_ncs_nxt;
      r_sck    <= w_sck_nxt;
      r_busy   <= w_busy_nxt;
      r_temp   <= w_temp_nxt;
      r_valid  <= w_valid_nxt;
      r_stb    <= w_stb_nxt;
      r_ot     <= w_ot_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_cnt_nxt    = r_cnt;
    w_bitcnt_nxt = r_bitcnt;
    w_shreg_nxt  = r_shreg;
    w_ncs_nxt    = r_ncs;
    w_sck_nxt    = r_sck;
    w_busy_nxt   = r_busy;
    w_temp_nxt   = r_temp;
    w_valid_nxt  = r_valid;
    w_stb_nxt    = 1'b0;
    w_ot_nxt     = r_ot;

    case (r_state)
      ST_WAIT: begin
        // A request coinciding with timer expiry still yields one frame.
        if ((r_timer == '0) || TEMP_REQ) begin
          w_state_nxt  = ST_SETUP;
          w_ncs_nxt    = 1'b0;
          w_busy_nxt   = 1'b1;
          w_cnt_nxt    = '0;
          w_bitcnt_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      ST_SETUP: begin
        if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
          w_state_nxt = ST_LOW;
          w_sck_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (w_sample_en) begin
          w_shreg_nxt = {r_shreg[TC77_FRAME_BITS-2:0], r_sio_q};
        end
        if (w_sck_rise) begin
          w_state_nxt = ST_HIGH;
          w_sck_nxt   = 1'b1;
        end
      end
      ST_HIGH: begin
        if (w_sck_fall) begin
          w_bitcnt_nxt = w_bitcnt_inc;
          if (w_bitcnt_inc == BIT_W'(TC77_FRAME_BITS)) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_LOW;
            w_sck_nxt   = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
          w_state_nxt = ST_EVAL;
          w_ncs_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_EVAL: begin
        w_state_nxt = ST_WAIT;
        w_busy_nxt  = 1'b0;
        if (w_conv) begin
          w_temp_nxt  = w_new_temp;
          w_valid_nxt = 1'b1;
          w_stb_nxt   = 1'b1;
          w_timer_nxt = TMR_W'(POLL_PERIOD - 1);
          // Signed compares: negative readings can only clear the flag.
          if (w_new_deg >= OT_SET_S) begin
            w_ot_nxt = 1'b1;
          end else if (w_new_deg < OT_CLR_S) begin
            w_ot_nxt = 1'b0;
          end
        end else begin
          w_timer_nxt = TMR_W'(RETRY_DELAY - 1);
        end
      end
      default: begin
        w_state_nxt = ST_WAIT;
      end
    endcase
  end

  assign nCS        = r_ncs;
  assign SCK        = r_sck;
  assign BUSY       = r_busy;
  assign TEMP_DATA  = r_temp;
  assign TEMP_DEG   = r_temp[TC77_TEMP_W-1:4];
  assign TEMP_VALID = r_valid;
  assign TEMP_STB   = r_stb;
  assign OVERTEMP   = r_ot;

endmodule

// File: tb/tb_tc77_reader.sv
`timescale 1ns/1ps
module tb_tc77_reader;

  localparam int unsigned POLL  = 3000;
  localparam int unsigned RETRY = 600;

  logic        MCLK = 1'b0;
  logic        nRESET = 1'b1;
  logic        TEMP_REQ = 1'b0;
  logic        nCS, SCK, BUSY, TEMP_VALID, TEMP_STB, OVERTEMP;
  logic        SIO = 1'b1;
  logic [12:0] TEMP_DATA;
  logic [8:0]  TEMP_DEG;

  tc77_reader #(
    .POLL_PERIOD (POLL),
    .RETRY_DELAY (RETRY)
  ) dut (
    .MCLK       (MCLK),
    .nRESET     (nRESET),
    .TEMP_REQ   (TEMP_REQ),
    .nCS        (nCS),
    .SCK        (SCK),
    .SIO        (SIO),
    .BUSY       (BUSY),
    .TEMP_DATA  (TEMP_DATA),
    .TEMP_DEG   (TEMP_DEG),
    .TEMP_VALID (TEMP_VALID),
    .TEMP_STB   (TEMP_STB),
    .OVERTEMP   (OVERTEMP)
  );

  always #10.417 MCLK = ~MCLK;

  typedef struct packed {
    logic [12:0] t;
    logic        c;
    logic [12:0] data;
    logic [8:0]  deg;
    logic        valid;
    logic        ot;
    logic        stb;
  } vec_t;

  vec_t        vecs [13];
  vec_t        sb_q [$];
  logic [15:0] sens_q [$];
  vec_t        cur;
  bit          cur_valid = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  bit req_chk = 0;
  int exp_gap = 0;
  int rise_cyc = 0;
  bit have_rise = 0;
  bit aborted = 0;
  int falls = 0;
  int low_cyc = 0;
  logic prev_ncs = 1'b1, prev_sck = 1'b1, prev_busy = 1'b0;

  always @(posedge MCLK) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [12:0] t, input logic c, input logic [12:0] d,
                              input logic [8:0] g, input logic v, input logic o, input logic s);
    vec_t r;
    r.t = t; r.c = c; r.data = d; r.deg = g; r.valid = v; r.ot = o; r.stb = s;
    return r;
  endfunction

  // Behavioural TC77: loads a word at nCS fall, shifts MSB-first on SCK falls.
  logic [15:0] sens_sh = '0;
  logic        sens_bit;
  always @(negedge nCS) begin
    if (sens_q.size() > 0) sens_sh = sens_q.pop_front();
    else sens_sh = 16'h0000;
  end
  always @(negedge SCK) begin
    if (!nCS) begin
      sens_bit = sens_sh[15];
      sens_sh  = {sens_sh[14:0], 1'b0};
      #5 SIO = sens_bit;
    end
  end
  always @(posedge nCS) SIO = 1'b1;

  // Reset values, checked right after every reset assertion.
  always @(negedge nRESET) begin
    aborted   = 1;
    cur_valid = 0;
    have_rise = 0;
    req_chk   = 0;
    #1;
    chk("rst_ncs", nCS, 1);
    chk("rst_sck", SCK, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_data", TEMP_DATA, 0);
    chk("rst_deg", TEMP_DEG, 0);
    chk("rst_valid", TEMP_VALID, 0);
    chk("rst_stb", TEMP_STB, 0);
    chk("rst_ot", OVERTEMP, 0);
  end

  // Monitor: frame shape, start latency, gaps, and scoreboard results.
  always @(negedge MCLK) begin
    if (nRESET) begin
      if (prev_ncs && !nCS) begin
        chk("sck_at_cs_fall", SCK, 1);
        if (req_chk) begin
          chk("start_latency", cyc - req_cyc, 1);
          req_chk = 0;
        end
        if (exp_gap != 0 && have_rise) begin
          chk("frame_gap", cyc - rise_cyc, exp_gap);
          exp_gap = 0;
        end
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: nCS fell with no frame expected (cycle %0d)", cyc);
          cur_valid = 0;
        end else begin
          cur = sb_q.pop_front();
          cur_valid = 1;
        end
        falls = 0;
        low_cyc = 0;
        aborted = 0;
      end
      if (!nCS) begin
        low_cyc++;
        if (prev_sck && !SCK) falls++;
      end
      if (!prev_ncs && nCS) begin
        if (!aborted) begin
          chk("sck_falls", falls, 16);
          chk("ncs_low_cycles", low_cyc, 264);
          chk("sck_at_cs_rise", SCK, 1);
        end
        rise_cyc = cyc;
        have_rise = 1;
      end
      if (prev_busy && !BUSY && cur_valid && !aborted) begin
        chk("temp_stb", TEMP_STB, cur.stb);
        chk("temp_data", TEMP_DATA, cur.data);
        chk("temp_deg", TEMP_DEG, cur.deg);
        chk("temp_valid", TEMP_VALID, cur.valid);
        chk("overtemp", OVERTEMP, cur.ot);
        cur_valid = 0;
      end else if (TEMP_STB) begin
        checks++;
        errors++;
        $display("FAIL stray_stb: TEMP_STB got 1 expected 0 (cycle %0d)", cyc);
      end
    end
    prev_ncs  = nCS;
    prev_sck  = SCK;
    prev_busy = BUSY;
  end

  task automatic push_frame(input int i);
    sb_q.push_back(vecs[i]);
    sens_q.push_back({vecs[i].t, vecs[i].c, 2'b11});
  endtask

  task automatic issue_req();
    @(negedge MCLK);
    TEMP_REQ = 1'b1;
    req_cyc = cyc;
    req_chk = 1;
    @(negedge MCLK);
    TEMP_REQ = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || cur_valid) && n < 5000) begin
      @(negedge MCLK);
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || cur_valid) begin
      errors++;
      $display("FAIL %s: frame not completed, got %0d pending expected 0", nm, sb_q.size());
      sb_q.delete();
      cur_valid = 0;
    end
  endtask

  initial begin
    int n;
    //            temp      conv  data      deg     v  ot stb
    vecs[0]  = mk(13'h0190, 1'b0, 13'h0000, 9'h000, 0, 0, 0);
    vecs[1]  = mk(13'h0100, 1'b1, 13'h0100, 9'h010, 1, 0, 1);
    vecs[2]  = mk(13'h02D0, 1'b1, 13'h02D0, 9'h02D, 1, 1, 1);
    vecs[3]  = mk(13'h02A0, 1'b1, 13'h02A0, 9'h02A, 1, 1, 1);
    vecs[4]  = mk(13'h0280, 1'b1, 13'h0280, 9'h028, 1, 1, 1);
    vecs[5]  = mk(13'h0270, 1'b1, 13'h0270, 9'h027, 1, 0, 1);
    vecs[6]  = mk(13'h02C0, 1'b1, 13'h02C0, 9'h02C, 1, 0, 1);
    vecs[7]  = mk(13'h1FF0, 1'b1, 13'h1FF0, 9'h1FF, 1, 0, 1);
    vecs[8]  = mk(13'h00AA, 1'b0, 13'h1FF0, 9'h1FF, 1, 0, 0);
    vecs[9]  = mk(13'h00C8, 1'b1, 13'h00C8, 9'h00C, 1, 0, 1);
    vecs[10] = mk(13'h0190, 1'b1, 13'h0190, 9'h019, 1, 0, 1);
    vecs[11] = mk(13'h02D0, 1'b1, 13'h02D0, 9'h02D, 1, 1, 1);
    vecs[12] = mk(13'h1D80, 1'b1, 13'h1D80, 9'h1D8, 1, 0, 1);

    #2 nRESET = 1'b0;
    push_frame(0);
    push_frame(1);
    exp_gap = RETRY + 1;
    repeat (3) @(negedge MCLK);
    nRESET = 1'b1;
    req_cyc = cyc;
    req_chk = 1;
    wait_drain("drain_conv0_then_retry");

    exp_gap = POLL + 1;
    push_frame(2);
    wait_drain("drain_poll_frame");

    for (int i = 3; i <= 8; i++) begin
      push_frame(i);
      issue_req();
      wait_drain("drain_req_frame");
    end

    push_frame(9);
    issue_req();
    repeat (100) @(negedge MCLK);
    TEMP_REQ = 1'b1;
    @(negedge MCLK);
    TEMP_REQ = 1'b0;
    wait_drain("drain_midframe_req");
    repeat (300) @(negedge MCLK);

    push_frame(10);
    issue_req();
    repeat (3) @(negedge MCLK);
    n = 0;
    while (falls < 7 && n < 1000) begin
      @(negedge MCLK);
      n++;
    end
    chk("reach_bit7", (falls >= 7) ? 1 : 0, 1);
    @(posedge MCLK);
    #3 nRESET = 1'b0;
    repeat (3) @(negedge MCLK);
    sb_q.delete();
    sens_q.delete();
    push_frame(11);
    @(negedge MCLK);
    nRESET = 1'b1;
    req_cyc = cyc;
    req_chk = 1;
    wait_drain("drain_after_reset");

    push_frame(12);
    issue_req();
    wait_drain("drain_negative");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
